// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// uart_tx_engine : write-side TX FIFO feeding a start/data/parity/stop serialiser
// Revision 1.0
// ============================================================================
module uart_tx_engine #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        tx_enable_i,
   input  logic [DIV_WIDTH-1:0]        div_i,
   input  logic [1:0]                  parity_mode_i,
   input  logic                        two_stop_i,
   input  logic                        wr_valid_i,
   input  logic [DATA_BITS-1:0]        wr_data_i,
   output logic                        wr_ready_o,
   output logic                        txd_o,
   output logic                        tx_full_o,
   output logic                        tx_empty_o,
   output logic [$clog2(FIFO_DEPTH):0] tx_level_o,
   output logic                        busy_o,
   output logic                        done_o
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int BCW = $clog2(DATA_BITS);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] clk_cnt_q, clk_cnt_d, div_q, div_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic [1:0]           pmode_q, pmode_d;
   logic                 two_stop_q, two_stop_d;
   logic                 txd_q, txd_d;
   logic                 done_q, done_d;

   logic                 full, empty, push, pop, launch, bit_end, parity_en;
   logic [DATA_BITS-1:0] head;

   assign full      = (level_q == LW'(FIFO_DEPTH));
   assign empty     = (level_q == '0);
   assign push      = wr_valid_i && !full;
   assign head      = mem_q[rd_ptr_q];
   assign bit_end   = (clk_cnt_q == div_q);
   assign parity_en = (pmode_q == 2'b01) || (pmode_q == 2'b10);

   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      pmode_d    = pmode_q;
      two_stop_d = two_stop_q;
      div_d      = div_q;
      txd_d      = txd_q;
      done_d     = 1'b0;
      launch     = 1'b0;
      pop        = 1'b0;

      // Clock counter reloads at every bit boundary so each bit lasts div+1 clocks.
      if (state_q != S_IDLE) begin
         clk_cnt_d = bit_end ? '0 : clk_cnt_q + DIV_WIDTH'(1);
      end

      case (state_q)
         S_IDLE: begin
            txd_d  = 1'b1;
            launch = tx_enable_i && !empty;
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               txd_d     = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  if (parity_en) begin
                     state_d = S_PARITY;
                     txd_d   = (pmode_q == 2'b10) ? ~par_q : par_q;
                  end else begin
                     state_d = S_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  txd_d     = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d   = S_STOP;
               txd_d     = 1'b1;
               bit_cnt_d = '0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (two_stop_q && (bit_cnt_q == '0)) begin
                  bit_cnt_d = BCW'(1);
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
                  txd_d   = 1'b1;
                  launch  = tx_enable_i && !empty;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
         end
      endcase

      // Frame configuration is captured with the character so later input changes cannot disturb it.
      if (launch) begin
         pop        = 1'b1;
         state_d    = S_START;
         txd_d      = 1'b0;
         clk_cnt_d  = '0;
         shift_d    = head;
         par_d      = ^head;
         pmode_d    = parity_mode_i;
         two_stop_d = two_stop_i;
         div_d      = div_i;
      end

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         clk_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         pmode_q    <= 2'b00;
         two_stop_q <= 1'b0;
         div_q      <= '0;
         txd_q      <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         pmode_q    <= pmode_d;
         two_stop_q <= two_stop_d;
         div_q      <= div_d;
         txd_q      <= txd_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign wr_ready_o = !full;
   assign tx_full_o  = full;
   assign tx_empty_o = empty;
   assign tx_level_o = level_q;
   assign txd_o      = txd_q;
   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// tb_uart_tx_engine : directed stimulus, queue-based frame model checked every cycle,
// plus literal expectations for framing, parity, full handling and abort.
module tb_uart_tx_engine;

   localparam int DEPTH = 8;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        clk_run   = 1'b0;
   logic        tx_enable = 1'b0;
   logic [15:0] div       = 16'd3;
   logic [1:0]  pmode     = 2'b00;
   logic        two_stop  = 1'b0;
   logic        wr_valid  = 1'b0;
   logic [7:0]  wr_data   = 8'h00;

   logic        wr_ready_o, txd_o, tx_full_o, tx_empty_o, busy_o, done_o;
   logic [3:0]  tx_level_o;

   int n_chk    = 0;
   int n_err    = 0;
   int done_cnt = 0;

   logic       stream[$];
   logic [7:0] mfifo[$];
   logic       m_done = 1'b0;
   int         m_sz;
   logic       m_ended;
   logic [7:0] m_b;

   logic wave [0:1023];
   int   cap_len;

   uart_tx_engine #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .tx_enable_i   (tx_enable),
      .div_i         (div),
      .parity_mode_i (pmode),
      .two_stop_i    (two_stop),
      .wr_valid_i    (wr_valid),
      .wr_data_i     (wr_data),
      .wr_ready_o    (wr_ready_o),
      .txd_o         (txd_o),
      .tx_full_o     (tx_full_o),
      .tx_empty_o    (tx_empty_o),
      .tx_level_o    (tx_level_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   initial begin
      wait (clk_run);
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expand one character into the per-clock txd values of its whole frame.
   task automatic add_frame(input logic [7:0] d);
      logic b[$];
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) b.push_back(d[i]);
      if (pmode == 2'b01) b.push_back(^d);
      else if (pmode == 2'b10) b.push_back(~^d);
      b.push_back(1'b1);
      if (two_stop) b.push_back(1'b1);
      foreach (b[i]) begin
         for (int r = 0; r <= int'(div); r++) stream.push_back(b[i]);
      end
   endtask

   // Model: a character queue and a stream of expected txd values, one per clock.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         stream.delete();
         mfifo.delete();
         m_done = 1'b0;
      end else begin
         m_sz    = mfifo.size();
         m_ended = 1'b0;
         if (stream.size() > 0) begin
            void'(stream.pop_front());
            m_ended = (stream.size() == 0);
         end
         m_done = m_ended;
         if (stream.size() == 0 && tx_enable && m_sz > 0) begin
            m_b = mfifo.pop_front();
            add_frame(m_b);
         end
         if (wr_valid && m_sz < DEPTH) mfifo.push_back(wr_data);
      end
   end

   initial forever begin
      @(negedge clk);
      if (done_o === 1'b1) done_cnt++;
      chk("txd",      {31'd0, txd_o},      {31'd0, (stream.size() > 0) ? stream[0] : 1'b1});
      chk("busy",     {31'd0, busy_o},     (stream.size() > 0) ? 32'd1 : 32'd0);
      chk("done",     {31'd0, done_o},     {31'd0, m_done});
      chk("level",    {28'd0, tx_level_o}, mfifo.size());
      chk("empty",    {31'd0, tx_empty_o}, (mfifo.size() == 0) ? 32'd1 : 32'd0);
      chk("full",     {31'd0, tx_full_o},  (mfifo.size() == DEPTH) ? 32'd1 : 32'd0);
      chk("wr_ready", {31'd0, wr_ready_o}, (mfifo.size() != DEPTH) ? 32'd1 : 32'd0);
   end

   task automatic write(input logic [7:0] d);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Record txd for every cycle busy is high, starting at the first busy cycle.
   task automatic capture(output int len);
      int guard;
      len   = 0;
      guard = 0;
      while (busy_o !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("busy_rise_timeout", (guard < 200) ? 32'd1 : 32'd0, 32'd1);
      while (busy_o === 1'b1 && len < 1024) begin
         wave[len] = txd_o;
         len++;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [9:0] got;
      int         d0;
      int         g;

      // Reset with no clock running
      #1 rst_n = 1'b0;
      #1;
      chk("rst_txd",      {31'd0, txd_o},      32'd1);
      chk("rst_empty",    {31'd0, tx_empty_o}, 32'd1);
      chk("rst_level",    {28'd0, tx_level_o}, 32'd0);
      chk("rst_wr_ready", {31'd0, wr_ready_o}, 32'd1);
      chk("rst_busy",     {31'd0, busy_o},     32'd0);
      chk("rst_full",     {31'd0, tx_full_o},  32'd0);
      clk_run = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 8N1 at div=3, 0xA5
      tx_enable = 1'b1; div = 16'd3; pmode = 2'b00; two_stop = 1'b0;
      d0 = done_cnt;
      write(8'hA5);
      capture(cap_len);
      for (int i = 0; i < 10; i++) got[i] = wave[i*4+1];
      chk("a5_bits", {22'd0, got}, {22'd0, 10'b1101001010});
      chk("a5_len",  cap_len, 32'd40);
      chk("a5_done", done_cnt - d0, 32'd1);
      chk("a5_idle", {31'd0, busy_o}, 32'd0);

      // Even parity, two stop bits, 0x07
      pmode = 2'b01; two_stop = 1'b1;
      write(8'h07);
      capture(cap_len);
      chk("e7_bit0",   {31'd0, wave[5]},  32'd1);
      chk("e7_parity", {31'd0, wave[37]}, 32'd1);
      chk("e7_stop1",  {31'd0, wave[41]}, 32'd1);
      chk("e7_stop2",  {31'd0, wave[45]}, 32'd1);
      chk("e7_len",    cap_len, 32'd48);

      // Odd parity, one stop bit, 0x07
      pmode = 2'b10; two_stop = 1'b0;
      write(8'h07);
      capture(cap_len);
      chk("o7_parity", {31'd0, wave[37]}, 32'd0);
      chk("o7_len",    cap_len, 32'd44);

      // Fill while disabled: 9 writes, the ninth dropped; then drain at div=0
      tx_enable = 1'b0; div = 16'd0; pmode = 2'b00;
      @(negedge clk);
      wr_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wr_data = 8'(8'h10 + i);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      chk("fill_full",     {31'd0, tx_full_o},  32'd1);
      chk("fill_wr_ready", {31'd0, wr_ready_o}, 32'd0);
      chk("fill_level",    {28'd0, tx_level_o}, 32'd8);
      d0 = done_cnt;
      tx_enable = 1'b1;
      capture(cap_len);
      chk("burst_len",   cap_len, 32'd80);
      chk("burst_done",  done_cnt - d0, 32'd8);
      chk("burst_empty", {31'd0, tx_empty_o}, 32'd1);

      // Simultaneous write and pop at level 1, continuing across pointer wrap
      tx_enable = 1'b0;
      d0 = done_cnt;
      write(8'h30);
      chk("sim_pre_level", {28'd0, tx_level_o}, 32'd1);
      tx_enable = 1'b1; wr_valid = 1'b1; wr_data = 8'h31;
      @(negedge clk);
      wr_valid = 1'b0;
      chk("sim_level", {28'd0, tx_level_o}, 32'd1);
      chk("sim_busy",  {31'd0, busy_o},     32'd1);
      for (int i = 2; i < 8; i++) begin
         write(8'(8'h30 + i));
         @(negedge clk);
      end
      g = 0;
      while ((busy_o === 1'b1 || tx_empty_o !== 1'b1) && g < 500) begin
         @(negedge clk);
         g++;
      end
      chk("sim_drain_timeout", (g < 500) ? 32'd1 : 32'd0, 32'd1);
      repeat (2) @(negedge clk);
      chk("sim_done", done_cnt - d0, 32'd8);

      // Abort during data bit 3 with a second character queued
      div = 16'd3; pmode = 2'b00; two_stop = 1'b0; tx_enable = 1'b1;
      @(negedge clk);
      wr_valid = 1'b1; wr_data = 8'hA5;
      @(negedge clk);
      wr_data = 8'h3C;
      @(negedge clk);
      wr_valid = 1'b0;
      repeat (17) @(negedge clk);
      chk("abort_pre_txd",   {31'd0, txd_o},      32'd0);
      chk("abort_pre_level", {28'd0, tx_level_o}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_txd",   {31'd0, txd_o},      32'd1);
      chk("abort_empty", {31'd0, tx_empty_o}, 32'd1);
      chk("abort_level", {28'd0, tx_level_o}, 32'd0);
      chk("abort_busy",  {31'd0, busy_o},     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      write(8'h3C);
      capture(cap_len);
      for (int i = 0; i < 10; i++) got[i] = wave[i*4+1];
      chk("post_bits", {22'd0, got}, {22'd0, 10'b1001111000});
      chk("post_len",  cap_len, 32'd40);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
